// File: rtl/dpwm_setpoint_reader.sv
// ---------------------------------------------------------------------------
// dpwm_setpoint_reader
//
// Purpose:
//   Receives the 10-bit current setpoint produced by the button-driven
//   up/down counter. The bus is asynchronous to clk, so it is passed through
//   a two-flop synchronizer. A new value is accepted only after it has been
//   seen unchanged for STABLE_CYC consecutive samples. The accepted value is
//   then clamped to MAX_SETPOINT and double-buffered into a shadow register
//   once per PWM period. The shadow register sets the DPWM high time in clock
//   counts.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   enable        in   1   1 = PWM running, 0 = output parked low
//   setpoint_in   in   10  setpoint bus from the up/down counter (async)
//   pwm_out       out  1   registered DPWM output
//   period_start  out  1   one-cycle pulse on the first cycle of each period
//   active_sp     out  10  setpoint currently in force (shadow register)
//   sat_flag      out  1   accepted setpoint exceeds MAX_SETPOINT
// ---------------------------------------------------------------------------
module dpwm_setpoint_reader #(
    parameter int PERIOD       = 1000,
    parameter int MAX_SETPOINT = 1000,
    parameter int RESET_SP     = 500,
    parameter int STABLE_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] setpoint_in,
    output logic       pwm_out,
    output logic       period_start,
    output logic [9:0] active_sp,
    output logic       sat_flag
);

    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC + 1) : 1;

    localparam logic [9:0]        RESET_VAL = 10'(RESET_SP);
    localparam logic [9:0]        MAX_VAL   = 10'(MAX_SETPOINT);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PERIOD - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);

    logic [9:0]        sync1_q, sync1_d;
    logic [9:0]        sync2_q, sync2_d;
    logic [9:0]        cand_q, cand_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [9:0]        accepted_q, accepted_d;
    logic [9:0]        shadow_q, shadow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              running_q, running_d;
    logic              pwm_q, pwm_d;
    logic              period_start_q, period_start_d;
    logic              sat_q, sat_d;
    logic [9:0]        clamped;

    // Next-state logic for the whole block. The synchronizer, the stability
    // filter, the clamp, the period counter and the double buffer are all
    // computed here, so the registered outputs line up with cnt_q and shadow_q.
    // running_q records that the previous cycle was enabled. The first enabled
    // cycle after a disabled stretch (or after reset) therefore starts a fresh
    // period at cnt == 0 with a period_start pulse.
    always_comb begin
        sync1_d    = setpoint_in;
        sync2_d    = sync1_q;
        cand_d     = cand_q;
        stab_cnt_d = stab_cnt_q;
        accepted_d = accepted_q;

        // Stability filter: the candidate must match the synchronized bus for
        // STABLE_CYC samples in a row. This keeps a skewed multi-bit transition
        // from being taken as a setpoint.
        if (sync2_q != cand_q) begin
            cand_d     = sync2_q;
            stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
            accepted_d = cand_q;
        end else begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end

        clamped = (accepted_q > MAX_VAL) ? MAX_VAL : accepted_q;
        sat_d   = (accepted_q > MAX_VAL);

        running_d = enable;
        if (!enable || !running_q || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Double buffer: the duty changes only at a period boundary. While the
        // PWM is parked, the shadow follows the clamped value, so re-enabling
        // starts with the latest setpoint.
        shadow_d = shadow_q;
        if (!enable || (cnt_q == LAST_CNT)) begin
            shadow_d = clamped;
        end

        period_start_d = enable && (cnt_d == '0);
        pwm_d          = enable && (32'(cnt_d) < 32'(shadow_d));
    end

    // State register. Every flop returns to its reset value as soon as reset
    // rises; no clock edge is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q        <= RESET_VAL;
            sync2_q        <= RESET_VAL;
            cand_q         <= RESET_VAL;
            stab_cnt_q     <= '0;
            accepted_q     <= RESET_VAL;
            shadow_q       <= RESET_VAL;
            cnt_q          <= '0;
            running_q      <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            sat_q          <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cand_q         <= cand_d;
            stab_cnt_q     <= stab_cnt_d;
            accepted_q     <= accepted_d;
            shadow_q       <= shadow_d;
            cnt_q          <= cnt_d;
            running_q      <= running_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            sat_q          <= sat_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign active_sp    = shadow_q;
    assign sat_flag     = sat_q;

endmodule
